// File: rtl/bcd_xs3_seq.sv
// Sequential BCD to Excess-3 converter.
// One digit per clock through a shared 4-bit converter, LSB digit first.
module bcd_xs3_seq #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] xs3_out,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NDIG - 1);

  state_t            state;
  logic [4*NDIG-1:0] sr;
  logic [3:0]        cnt;
  logic [3:0]        dig;
  logic [3:0]        nib;
  logic              bad;

  always_comb begin
    dig = sr[3:0];
    bad = dig > 4'd9;
    nib = bad ? 4'h0 : dig + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sr      <= '0;
      xs3_out <= '0;
      err     <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sr      <= bcd_in;
            xs3_out <= '0;
            err     <= 1'b0;
            cnt     <= '0;
            state   <= CONV;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        CONV: begin
          for (int i = 0; i < NDIG; i++) begin
            if (cnt == 4'(i)) xs3_out[4*i +: 4] <= nib;
          end
          if (bad) err <= 1'b1;
          sr  <= sr >> 4;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Randomised bench for bcd_xs3_seq with a timeline-based model
// checked every cycle, plus literal expectations for known words.
module tb_bcd_xs3_seq;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] bcd_in = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] xs3_out;
  logic         err;

  int vectors = 0;
  int misses  = 0;

  bcd_xs3_seq #(.NDIG(NDIG)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .xs3_out (xs3_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Excess-3 of the low n digits of w; higher nibbles stay zero.
  function automatic logic [W-1:0] conv(input logic [W-1:0] w,
                                        input int n);
    logic [W-1:0] r;
    int d;
    r = '0;
    for (int i = 0; i < n; i++) begin
      d = int'((w >> (4 * i)) & 4'hf);
      r[4*i +: 4] = (d <= 9) ? 4'(d + 3) : 4'h0;
    end
    return r;
  endfunction

  function automatic logic bad_any(input logic [W-1:0] w, input int n);
    logic b;
    b = 1'b0;
    for (int i = 0; i < n; i++)
      if (int'((w >> (4 * i)) & 4'hf) > 9) b = 1'b1;
    return b;
  endfunction

  // Model: k counts edges since the accepting edge (0 = idle).
  int           k = 0;
  logic [W-1:0] word = '0;
  logic [W-1:0] hold_x = '0;
  logic         hold_e = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k      <= 0;
      word   <= '0;
      hold_x <= '0;
      hold_e <= 1'b0;
    end else if (k == 0) begin
      if (start) begin
        k    <= 1;
        word <= bcd_in;
      end
    end else if (k == NDIG + 1) begin
      k      <= 0;
      hold_x <= conv(word, NDIG);
      hold_e <= bad_any(word, NDIG);
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0]   ectl;
    logic [W-1:0] ex;
    logic         ee;
    ectl = {k == 0, k >= 1 && k <= NDIG, k == NDIG + 1};
    ex   = (k == 0) ? hold_x : conv(word, k - 1);
    ee   = (k == 0) ? hold_e : bad_any(word, k - 1);
    chk("ctl", 32'({ready, busy, done}), 32'(ectl));
    chk("xs3", 32'(xs3_out), 32'(ex));
    chk("err", 32'(err), 32'(ee));
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_word(input logic [W-1:0] w, input bit pin,
                          input logic [W-1:0] ex, input logic ee);
    int n = 0;
    wait_ready();
    start  = 1'b1;
    bcd_in = w;
    @(posedge clk);
    #2;
    start  = 1'b0;
    bcd_in = W'($urandom);
    while (!done && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    else if (pin) begin
      chk("lit_xs3", 32'(xs3_out), 32'(ex));
      chk("lit_err", 32'(err), 32'(ee));
    end
  endtask

  initial begin
    int ndone;
    logic [W-1:0] w;
    #1 rst = 1'b1;
    #1;
    chk("rst_ctl", 32'({ready, busy, done}), 32'b100);
    chk("rst_xs3", 32'(xs3_out), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    run_word(16'h1234, 1, 16'h4567, 1'b0);
    run_word(16'h9090, 1, 16'hC3C3, 1'b0);
    run_word(16'h0000, 1, 16'h3333, 1'b0);
    run_word(16'h12A4, 1, 16'h4507, 1'b1);
    run_word(16'h0001, 1, 16'h3334, 1'b0);

    // start held high, bcd_in changing every cycle
    wait_ready();
    ndone = 0;
    for (int c = 0; c < 6 * 5; c++) begin
      start  = 1'b1;
      bcd_in = W'($urandom);
      @(negedge clk);
      if (done) ndone++;
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    chk("held_done_count", ndone, 5);

    // reset between edges in the second conversion cycle
    wait_ready();
    start  = 1'b1;
    bcd_in = 16'h5678;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_ctl", 32'({ready, busy, done}), 32'b100);
    chk("abort_xs3", 32'(xs3_out), 0);
    chk("abort_err", 32'(err), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_word(16'h0999, 1, 16'h3CCC, 1'b0);

    // every value in every digit position
    for (int p = 0; p < NDIG; p++) begin
      for (int v = 0; v < 16; v++) begin
        w = '0;
        for (int i = 0; i < NDIG; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
        w[4*p +: 4] = 4'(v);
        run_word(w, 0, '0, 1'b0);
        chk("sweep_nib", 32'((xs3_out >> (4 * p)) & 4'hf),
            (v <= 9) ? v + 3 : 0);
        chk("sweep_err", 32'(err), 32'(v > 9));
      end
    end

    for (int r = 0; r < 60; r++) run_word(W'($urandom), 0, '0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/bcd_xs3_seq.md
BCD_XS3_SEQ -- requirements
Module: bcd_xs3_seq

Interface
REQ-001 Parameter NDIG, default 4: number of packed BCD digits per word; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to convert bcd_in; sampled only when ready=1.
REQ-005 bcd_in  input  4*NDIG  packed BCD word; digit 0 is bits [3:0].
REQ-006 ready  output  1  high in IDLE; start is accepted.
REQ-007 busy  output  1  high while digits are being converted.
REQ-008 done  output  1  single-cycle pulse: conversion complete, xs3_out and err valid.
REQ-009 xs3_out  output  4*NDIG  packed Excess-3 result; nibble i corresponds to BCD digit i.
REQ-010 err  output  1  set if any digit of the accepted word was greater than 9.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, CONV and DONE.
REQ-012 IDLE: ready=1, busy=0; start=1 at a rising edge SHALL capture bcd_in into an internal shift register, clear xs3_out to 0, clear err, zero the digit counter, and move to CONV.
REQ-013 IDLE with start=0 SHALL hold state and all outputs.
REQ-014 CONV: ready=0, busy=1; at each rising edge, exactly one digit SHALL be converted, LSB digit first, through a single shared 4-bit converter.
REQ-015 Converter map: BCD value d in 0..9 SHALL produce d+3 (0->3 ... 9->12), 4-bit result, no carry.
REQ-016 Digit value 10..15 SHALL write nibble 4'h0 and set err; err is sticky until the next accepted start.
REQ-017 The converted nibble for digit i SHALL be written to xs3_out[4i+3:4i]; other nibbles are unchanged.
REQ-018 Counter SHALL advance 0..NDIG-1; the edge converting digit NDIG-1 SHALL move the FSM to DONE.
REQ-019 DONE: done=1, busy=0, ready=0 for exactly one cycle, then unconditional return to IDLE.
REQ-020 Latency: start accepted at edge E0; done SHALL be high in the cycle following edge E(NDIG); ready SHALL return after edge E(NDIG+1).
REQ-021 start while in CONV or DONE SHALL be ignored, with no queuing; bcd_in changes after capture SHALL have no effect.
REQ-022 xs3_out and err SHALL hold their final values after DONE until the next accepted start.
REQ-023 Exactly one of ready, busy, done SHALL be high in every cycle outside reset.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, counter=0, shift register=0, xs3_out=0, err=0, done=0, busy=0, ready=1, independent of clk.
REQ-025 rst asserted during CONV or DONE SHALL abort the conversion with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-026 NDIG=4, bcd_in=16'h1234, start pulse -> busy for 4 cycles, done pulse in 5th cycle, xs3_out=16'h4567, err=0.
REQ-027 bcd_in=16'h9090, then 16'h0000 back-to-back (start asserted on first ready cycle after done) -> xs3_out=16'hC3C3, then 16'h3333; err=0 both times.
REQ-028 bcd_in=16'h12A4 -> xs3_out=16'h4507, err=1 at done; next word 16'h0001 -> err=0, xs3_out=16'h3334.
REQ-029 start held high continuously with bcd_in changing each cycle -> only the word present in the accepted IDLE cycle is converted; one done pulse per NDIG+2 cycles.
REQ-030 rst asserted between clock edges during the 2nd CONV cycle -> outputs take reset values without waiting for a clk edge, no done pulse; subsequent start with 16'h0999 -> xs3_out=16'h3CCC.
REQ-031 Sweep all 16 values in every digit position -> values 0..9 map to 3..12 and values 10..15 map to 0 with err=1; each done pulse lasts exactly one cycle.
